// File: rtl/vending_machine_param.sv
// vending_machine_param: multi-item vending controller with a capped credit
// register, explicit buy/cancel and largest-first change dispensing.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no credit held
// ST_CREDIT | credit > 0, accepting coins, waiting for buy/cancel/auto-vend
// ST_CHANGE | returning credit, one coin per cycle (20, then 10, then 5)
module vending_machine_param #(
  parameter int                          N_ITEMS    = 2,
  parameter int                          SEL_W      = 1,
  parameter int                          CREDIT_W   = 8,
  parameter int                          MAX_CREDIT = 50,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {8'd25, 8'd15},
  parameter bit                          AUTO_VEND  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    item,
  output logic [1:0]          change,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  // Arithmetic on coin totals uses one extra bit so credit + coin cannot wrap
  // before it is compared against the credit ceiling.
  localparam logic [CREDIT_W:0]   MAX_W     = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [SEL_W:0]      N_ITEMS_W = (SEL_W+1)'(N_ITEMS);
  localparam logic [CREDIT_W-1:0] V5        = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] V10       = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] V20       = CREDIT_W'(20);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic [1:0]          change_q, change_d;
  logic                coin_reject_q, coin_reject_d;

  logic [CREDIT_W:0]   coin_val;
  logic                coin_present;
  logic                sel_valid;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   total_w;
  logic [CREDIT_W:0]   eff_w;
  logic                reject_new;
  logic                vend_ok;

  // Decode the coin acceptor code into a monetary value.
  always_comb begin
    coin_val = '0;
    case (in)
      2'b01:   coin_val = (CREDIT_W+1)'(5);
      2'b10:   coin_val = (CREDIT_W+1)'(10);
      2'b11:   coin_val = (CREDIT_W+1)'(20);
      default: coin_val = '0;
    endcase
    coin_present = (in != 2'b00);
  end

  // Look up the price of the selected item; invalid selections price at 0
  // but are blocked from vending by sel_valid.
  always_comb begin
    sel_valid = ({1'b0, sel} < N_ITEMS_W);
    price     = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  // Coin acceptance and the credit the non-coin actions work from: a rejected
  // coin leaves the old credit in place for cancel/buy evaluation.
  always_comb begin
    total_w    = {1'b0, credit_q} + coin_val;
    reject_new = coin_present && ((total_w > MAX_W) || !sel_valid);
    eff_w      = reject_new ? {1'b0, credit_q} : total_w;
    vend_ok    = (AUTO_VEND || buy) && sel_valid && (eff_w >= {1'b0, price});
  end

  // Next-state and next-output computation for the vending FSM.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    out_d         = 1'b0;
    item_d        = '0;
    change_d      = 2'b00;
    coin_reject_d = 1'b0;

    case (state_q)
      ST_CHANGE: begin
        // Buy and cancel are ignored while paying out; any coin is bounced.
        coin_reject_d = coin_present;
        if (credit_q >= V20) begin
          change_d = 2'b11;
          credit_d = credit_q - V20;
        end else if (credit_q >= V10) begin
          change_d = 2'b10;
          credit_d = credit_q - V10;
        end else if (credit_q >= V5) begin
          change_d = 2'b01;
          credit_d = credit_q - V5;
        end else begin
          // Unreachable with multiple-of-5 values; drop any residue so the
          // machine can never stall in ST_CHANGE.
          credit_d = '0;
        end
        if (credit_d == '0) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        coin_reject_d = reject_new;
        if (cancel) begin
          credit_d = eff_w[CREDIT_W-1:0];
          state_d  = (eff_w != '0) ? ST_CHANGE : ST_IDLE;
        end else if (vend_ok) begin
          out_d    = 1'b1;
          item_d   = sel;
          credit_d = CREDIT_W'(eff_w - {1'b0, price});
          state_d  = (eff_w != {1'b0, price}) ? ST_CHANGE : ST_IDLE;
        end else begin
          credit_d = eff_w[CREDIT_W-1:0];
          state_d  = (eff_w != '0) ? ST_CREDIT : ST_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset forfeits credit and aborts payout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      out_q         <= 1'b0;
      item_q        <= '0;
      change_q      <= 2'b00;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      out_q         <= out_d;
      item_q        <= item_d;
      change_q      <= change_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign out         = out_q;
  assign item        = item_q;
  assign change      = change_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign busy        = (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: a default two-item instance and an
// auto-vend single-item instance, each shadowed by a value-level model.
module tb_vending_machine_param;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // default-configuration instance
  logic [1:0] in_p = 2'b00;
  logic       sel_p = 1'b0, buy_p = 1'b0, cancel_p = 1'b0;
  logic       out_p, item_p, rej_p, busy_p;
  logic [1:0] change_p;
  logic [7:0] credit_p;

  // auto-vend, single item priced 15
  logic [1:0] in_a = 2'b00;
  logic       sel_a = 1'b0, buy_a = 1'b0, cancel_a = 1'b0;
  logic       out_a, item_a, rej_a, busy_a;
  logic [1:0] change_a;
  logic [7:0] credit_a;

  vending_machine_param dut_p (
    .clk(clk), .rst_n(rst_n), .in(in_p), .sel(sel_p), .buy(buy_p),
    .cancel(cancel_p), .out(out_p), .item(item_p), .change(change_p),
    .coin_reject(rej_p), .busy(busy_p), .credit(credit_p)
  );

  vending_machine_param #(
    .N_ITEMS(1), .SEL_W(1), .CREDIT_W(8), .MAX_CREDIT(50),
    .PRICES(8'd15), .AUTO_VEND(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .sel(sel_a), .buy(buy_a),
    .cancel(cancel_a), .out(out_a), .item(item_a), .change(change_a),
    .coin_reject(rej_a), .busy(busy_a), .credit(credit_a)
  );

  int total_n = 0;
  int bad_n   = 0;

  task automatic cmp(string nm, int act, int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int credit;
    bit disp;
    bit out;
    int item;
    int change;
    bit rej;
  } mst_t;

  mst_t mp, ma;

  function automatic int coin_value(int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 20;
      default: return 0;
    endcase
  endfunction

  function automatic int coin_code(int value);
    case (value)
      5:  return 1;
      10: return 2;
      20: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic mst_t step(mst_t s, int code, int sel, bit buy, bit cancel,
                                int nitems, bit autov, int p0, int p1);
    mst_t n;
    int cv, eff, price, give;
    bit rej;
    n        = s;
    n.out    = 0;
    n.item   = 0;
    n.change = 0;
    n.rej    = 0;
    cv       = coin_value(code);
    if (s.disp) begin
      n.rej    = (cv != 0);
      give     = (s.credit >= 20) ? 20 : (s.credit >= 10) ? 10 : 5;
      n.change = coin_code(give);
      n.credit = s.credit - give;
      n.disp   = (n.credit > 0);
    end else begin
      rej   = (cv != 0) && ((s.credit + cv > 50) || (sel >= nitems));
      n.rej = rej;
      eff   = rej ? s.credit : s.credit + cv;
      price = (sel == 0) ? p0 : p1;
      if (cancel) begin
        n.credit = eff;
        n.disp   = (eff > 0);
      end else if ((autov || buy) && sel < nitems && eff >= price) begin
        n.out    = 1;
        n.item   = sel;
        n.credit = eff - price;
        n.disp   = (n.credit > 0);
      end else begin
        n.credit = eff;
        n.disp   = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp = '{default: 0};
      ma = '{default: 0};
    end else begin
      mp = step(mp, int'(in_p), int'(sel_p), buy_p, cancel_p, 2, 1'b0, 15, 25);
      ma = step(ma, int'(in_a), int'(sel_a), buy_a, cancel_a, 1, 1'b1, 15, 0);
    end
  end

  // compare both instances against the model every cycle
  always @(negedge clk) begin
    cmp("p_out", int'(out_p), int'(mp.out));
    if (mp.out) cmp("p_item", int'(item_p), mp.item);
    cmp("p_change", int'(change_p), mp.change);
    cmp("p_reject", int'(rej_p), int'(mp.rej));
    cmp("p_busy", int'(busy_p), int'(mp.disp));
    cmp("p_credit", int'(credit_p), mp.credit);
    cmp("a_out", int'(out_a), int'(ma.out));
    if (ma.out) cmp("a_item", int'(item_a), ma.item);
    cmp("a_change", int'(change_a), ma.change);
    cmp("a_reject", int'(rej_a), int'(ma.rej));
    cmp("a_busy", int'(busy_a), int'(ma.disp));
    cmp("a_credit", int'(credit_a), ma.credit);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin_p(logic [1:0] code);
    in_p = code;
    tick();
    in_p = 2'b00;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    tick();
    cmp("rst_credit", int'(credit_p), 0);
    cmp("rst_out", int'(out_p), 0);
    cmp("rst_change", int'(change_p), 0);
    cmp("rst_reject", int'(rej_p), 0);
    cmp("rst_busy", int'(busy_p), 0);
    rst_n = 1'b1;
    tick();

    // auto-vend: 5+5+5 vends exactly
    in_a = 2'b01;
    repeat (3) tick();
    in_a = 2'b00;
    cmp("auto15_out", int'(out_a), 1);
    cmp("auto15_credit", int'(credit_a), 0);
    cmp("auto15_change", int'(change_a), 0);
    tick();
    cmp("auto15_out_drop", int'(out_a), 0);
    cmp("auto15_change_idle", int'(change_a), 0);
    // auto-vend: 10+10 vends with 5 change
    in_a = 2'b10;
    tick();
    cmp("auto20_no_out", int'(out_a), 0);
    tick();
    in_a = 2'b00;
    cmp("auto20_out", int'(out_a), 1);
    cmp("auto20_credit", int'(credit_a), 5);
    tick();
    cmp("auto20_change", int'(change_a), 1);
    cmp("auto20_credit0", int'(credit_a), 0);
    tick();
    cmp("auto20_change_end", int'(change_a), 0);

    // 20+10, buy item 1 (price 25) -> 5 change
    coin_p(2'b11);
    coin_p(2'b10);
    cmp("buy1_credit30", int'(credit_p), 30);
    sel_p = 1'b1;
    buy_p = 1'b1;
    tick();
    buy_p = 1'b0;
    cmp("buy1_out", int'(out_p), 1);
    cmp("buy1_item", int'(item_p), 1);
    cmp("buy1_busy", int'(busy_p), 1);
    cmp("buy1_credit5", int'(credit_p), 5);
    tick();
    cmp("buy1_change", int'(change_p), 1);
    cmp("buy1_out_drop", int'(out_p), 0);
    cmp("buy1_busy_drop", int'(busy_p), 0);
    cmp("buy1_credit0", int'(credit_p), 0);
    tick();
    cmp("buy1_change_end", int'(change_p), 0);

    // insufficient credit, then top-up with buy held
    coin_p(2'b10);
    sel_p = 1'b0;
    buy_p = 1'b1;
    tick();
    cmp("short_no_out", int'(out_p), 0);
    cmp("short_credit", int'(credit_p), 10);
    in_p = 2'b01;
    tick();
    in_p  = 2'b00;
    buy_p = 1'b0;
    cmp("topup_out", int'(out_p), 1);
    cmp("topup_item", int'(item_p), 0);
    cmp("topup_credit", int'(credit_p), 0);
    cmp("topup_busy", int'(busy_p), 0);
    tick();

    // cancel with 35 -> 20,10,5
    coin_p(2'b11);
    coin_p(2'b10);
    coin_p(2'b01);
    cancel_p = 1'b1;
    tick();
    cancel_p = 1'b0;
    cmp("cancel35_busy", int'(busy_p), 1);
    cmp("cancel35_credit", int'(credit_p), 35);
    tick();
    cmp("cancel35_c1", int'(change_p), 3);
    tick();
    cmp("cancel35_c2", int'(change_p), 2);
    cmp("cancel35_busy2", int'(busy_p), 1);
    tick();
    cmp("cancel35_c3", int'(change_p), 1);
    cmp("cancel35_idle", int'(busy_p), 0);
    cmp("cancel35_zero", int'(credit_p), 0);
    tick();
    cmp("cancel35_c4", int'(change_p), 0);

    // cancel beats buy
    coin_p(2'b11);
    coin_p(2'b10);
    cancel_p = 1'b1;
    buy_p    = 1'b1;
    sel_p    = 1'b0;
    tick();
    cancel_p = 1'b0;
    buy_p    = 1'b0;
    cmp("cb_no_out", int'(out_p), 0);
    cmp("cb_credit", int'(credit_p), 30);
    tick();
    cmp("cb_c1", int'(change_p), 3);
    tick();
    cmp("cb_c2", int'(change_p), 2);
    tick();

    // over-limit coin, then coin during payout
    coin_p(2'b11);
    coin_p(2'b11);
    coin_p(2'b11);
    cmp("over_reject", int'(rej_p), 1);
    cmp("over_credit", int'(credit_p), 40);
    tick();
    cmp("over_reject_drop", int'(rej_p), 0);
    cancel_p = 1'b1;
    tick();
    cancel_p = 1'b0;
    coin_p(2'b10);
    cmp("chg_reject", int'(rej_p), 1);
    cmp("chg_change", int'(change_p), 3);
    cmp("chg_credit", int'(credit_p), 20);
    tick();
    cmp("chg_credit_end", int'(credit_p), 0);
    tick();

    // reset mid-payout
    coin_p(2'b11);
    coin_p(2'b11);
    coin_p(2'b01);
    cancel_p = 1'b1;
    tick();
    cancel_p = 1'b0;
    tick();
    cmp("mid_credit25", int'(credit_p), 25);
    #2 rst_n = 1'b0;
    #1;
    cmp("mid_rst_change", int'(change_p), 0);
    cmp("mid_rst_out", int'(out_p), 0);
    cmp("mid_rst_credit", int'(credit_p), 0);
    cmp("mid_rst_busy", int'(busy_p), 0);
    tick();
    rst_n = 1'b1;
    tick();
    cmp("post_rst_busy", int'(busy_p), 0);
    cmp("post_rst_change", int'(change_p), 0);

    // randomized phase against the model
    for (int c = 0; c < 4000; c++) begin
      in_p     = 2'($urandom_range(0, 3));
      sel_p    = 1'($urandom_range(0, 1));
      buy_p    = ($urandom_range(0, 3) == 0);
      cancel_p = ($urandom_range(0, 19) == 0);
      in_a     = 2'($urandom_range(0, 3));
      sel_a    = ($urandom_range(0, 9) == 0);
      buy_a    = ($urandom_range(0, 1) == 0);
      cancel_a = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick();
    end
    in_p = 2'b00; buy_p = 1'b0; cancel_p = 1'b0;
    in_a = 2'b00; buy_a = 1'b0; cancel_a = 1'b0;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the single-price vending FSM: multiple items with per-item prices, a 20-unit coin, explicit buy/cancel, overflow-protected credit, and multi-cycle largest-first change dispensing.
- Sits between the coin acceptor (2-bit coin code) and the dispenser/change hopper.
- AUTO_VEND=1 with a single item priced 15 reproduces the legacy behaviour: vend on reaching price, with 5-unit change on overpay.

Parameters:
- N_ITEMS, 2, number of selectable items (1..8).
- SEL_W, 1, width of sel/item; must satisfy 2**SEL_W >= N_ITEMS.
- CREDIT_W, 8, width of the credit register.
- MAX_CREDIT, 50, maximum credit held; coins that would exceed it are rejected.
- PRICES, {8'd25, 8'd15}, flat vector of N_ITEMS fields, CREDIT_W bits each; item i is at bits [i*CREDIT_W +: CREDIT_W]. Each price is a nonzero multiple of 5 and <= MAX_CREDIT.
- AUTO_VEND, 0, 1 = vend the selected item as soon as credit >= price, with buy ignored; 0 = vend only on buy.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  2  coin this cycle: 00 none, 01 = 5, 10 = 10, 11 = 20
- sel  input  SEL_W  item select, sampled on the qualifying edge
- buy  input  1  purchase request (level sampled each edge)
- cancel  input  1  refund all credit
- out  output  1  one-cycle vend pulse
- item  output  SEL_W  item vended; valid while out=1
- change  output  2  one returned coin per cycle: 00 none, 01 = 5, 10 = 10, 11 = 20
- coin_reject  output  1  one-cycle pulse: the coin sampled on the previous edge was returned
- busy  output  1  high while dispensing change
- credit  output  CREDIT_W  current credit register

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, credit=0.
  - out, item, change and coin_reject are all 0.
  - Any credit held at reset is forfeited.
- States: IDLE (credit = 0), CREDIT (credit > 0), CHANGE (returning credit).
- All outputs are registered except busy, which is decoded from the state register.
- IDLE/CREDIT, each edge:
  - Compute total = credit + coin value.
  - If total > MAX_CREDIT, or sel >= N_ITEMS with a coin present: the coin is rejected. Set coin_reject=1 for the next cycle and keep credit unchanged; the non-coin actions below still evaluate against the old credit.
  - cancel=1 has priority over buy and vend. If total > 0, enter CHANGE with credit = total. An accepted same-cycle coin is refunded too.
  - Vend condition: (AUTO_VEND or buy) and sel < N_ITEMS and total >= PRICES[sel].
  - On vend: out=1 and item=sel for the next cycle; credit = total - price; go to CHANGE if the remainder is > 0, else IDLE.
  - buy with insufficient credit, or with an invalid sel: no vend, credit = total, no error pulse.
  - Otherwise credit = total, and the state is CREDIT if total > 0, else IDLE.
- CHANGE, each edge:
  - Emit the largest coin <= credit (20, then 10, then 5) on change for the next cycle, and subtract it from credit.
  - When credit reaches 0, go to IDLE. change returns to 00 the cycle after the last coin.
  - Coins arriving in CHANGE are rejected (coin_reject pulse); buy and cancel are ignored.
- Latency:
  - out appears one cycle after the qualifying edge.
  - The first change coin appears one cycle after out, or one cycle after cancel.
- out, coin_reject and change are single-cycle values; each returns to 0 unless re-asserted.
- Credit never exceeds MAX_CREDIT and never underflows. Change always completes exactly, because all values are multiples of 5.
- A reset during CHANGE aborts dispensing immediately, with no further coins.

Test Plan:
- AUTO_VEND=1, N_ITEMS=1, PRICES=15: coins 5, 5, 5 -> out=1 for one cycle after the third coin edge; change stays 00; credit=0. Then 10, 10 -> out=1, next cycle change=01, then 00; credit=0.
- Default config: coins 20, 10 (credit 30), sel=1, buy -> out=1, item=1; next cycle change=01; busy high for one cycle; then IDLE.
- Credit 10, sel=0, buy -> no out, credit stays 10. Then coin 5 with buy -> out=1, credit 0.
- Credit 35, cancel -> change sequence 11, 10, 01 on consecutive cycles, then 00; busy high for 3 cycles; credit 0. cancel and buy together with credit 30 -> refund only, no out.
- Credit 40 (MAX_CREDIT=50), coin 20 -> coin_reject=1 next cycle, credit 40. Coin 10 during CHANGE -> coin_reject=1, credit unaffected.
- rst_n low mid-CHANGE (credit 25 remaining) -> change, out and credit are 0 immediately, with no clock required; after release, state IDLE.
